fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle 16-bit CPU core. Owns the fetch PC, issues word-addressed requests to instruction memory over a valid/ready request and in-order response interface, and buffers returned words with their PCs in a small queue. Delivers instructions to decode over a valid/ready handshake, accepts jump/branch redirects from execute, and discards stale in-flight responses after a redirect.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_queue.sv | 56 +++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN = 16;
    localparam logic [XLEN-1:0] HALT_WORD = 16'hFFFF;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response, decode delivery, execute redirect, halt status.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready, redirect_valid, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready, redirect_valid, redirect_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, data} entries with flush and occupancy count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_wdata,
    output fetch_entry_t           o_rdata,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wptr <= r_wptr + AW'(1);
            if (i_pop)
                r_rptr <= r_rptr + AW'(1);
            if (i_push && !i_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage carries no reset; consumers qualify the head with o_empty.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, in-order response buffering, redirect flush.
// Optional halt-word detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] RESET_PC        = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master io_bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;
    logic            r_stop;
    logic            r_halted;

    logic            w_redir;
    logic            w_issue;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_keep;
    logic            w_pop;
    logic            w_inst_valid;
    logic            w_halt_hit;
    logic            w_halt_pop;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_out_next;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Queued plus in-flight words never exceed DEPTH, so a response always has a slot.
    always_comb begin
        w_redir      = io_bus.redirect_valid;
        w_inflight   = {1'b0, w_count} + {1'b0, r_outstanding};
        w_issue      = rst_n && !w_redir && !r_stop &&
                       (r_outstanding < MAX_OUT_C) && (w_inflight < DEPTH_C);
        w_req_fire   = w_issue && io_bus.imem_req_ready;
        w_rsp        = io_bus.imem_rsp_valid;
        w_keep       = w_rsp && (r_drop == '0) && !w_redir;
        w_inst_valid = !w_empty && !w_redir;
        w_pop        = w_inst_valid && io_bus.inst_ready;
        w_push_entry = '{pc: r_rsp_pc, data: io_bus.imem_rsp_data};
        w_out_next   = r_outstanding;
        if (w_req_fire && !w_rsp)
            w_out_next = r_outstanding + CW'(1);
        else if (!w_req_fire && w_rsp)
            w_out_next = r_outstanding - CW'(1);
`ifdef FETCH_HALT_DETECT_EN
        w_halt_hit   = w_keep && (io_bus.imem_rsp_data == HALT_WORD);
        w_halt_pop   = w_pop && (w_head.data == HALT_WORD);
`else
        w_halt_hit   = 1'b0;
        w_halt_pop   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_stop        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_redir) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= io_bus.redirect_pc;
                r_rsp_pc   <= io_bus.redirect_pc;
                r_drop     <= w_out_next;
                r_stop     <= 1'b0;
                r_halted   <= 1'b0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 16'd1;
                if (w_keep)
                    r_rsp_pc <= r_rsp_pc + 16'd1;
                if (w_halt_hit) begin
                    r_stop <= 1'b1;
                    r_drop <= w_out_next;
                end else if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
                if (w_halt_pop)
                    r_halted <= 1'b1;
            end
        end
    end

    assign io_bus.imem_req_valid = w_issue;
    assign io_bus.imem_req_addr  = r_fetch_pc;
    assign io_bus.inst_valid     = w_inst_valid;
    assign io_bus.inst_data      = w_inst_valid ? w_head.data : '0;
    assign io_bus.inst_pc        = w_inst_valid ? w_head.pc   : '0;
    assign io_bus.halted         = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural imem with configurable latency, in-order scoreboard, vector table.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct { logic [15:0] addr; int due; } pend_t;
    typedef struct {
        logic        inst_ready;
        logic        req_valid;
        logic [15:0] req_addr;
        logic        inst_valid;
        logic [15:0] pc;
        logic [15:0] data;
    } vec_t;

    pend_t        pend[$];
    fetch_entry_t sb[$];
    vec_t         tbl[10];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = 1;
    bit halt_en = 1'b0;

    logic        drv_req_ready, drv_inst_ready, drv_redir;
    logic [15:0] drv_redir_pc;
    logic [15:0] exp_addr;
    logic        m_halted;
    logic        s_fire, s_pop;
    logic [15:0] s_fire_addr, s_pop_pc, s_pop_data;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (halt_en && a == 16'h0005) return 16'hFFFF;
        return a + 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_sample();
        fetch_entry_t e;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 16'h0000;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(pend[0].addr);
            void'(pend.pop_front());
        end
        bus.imem_req_ready = drv_req_ready;
        bus.inst_ready     = drv_inst_ready;
        bus.redirect_valid = drv_redir;
        bus.redirect_pc    = drv_redir_pc;
        #1;
        chk("halted", bus.halted, m_halted);
        if (drv_redir) begin
            chk("req_valid_during_redirect", bus.imem_req_valid, 0);
            chk("inst_valid_during_redirect", bus.inst_valid, 0);
        end
        if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_addr);
        s_fire      = bus.imem_req_valid && drv_req_ready;
        s_fire_addr = bus.imem_req_addr;
        s_pop       = bus.inst_valid && drv_inst_ready;
        s_pop_pc    = bus.inst_pc;
        s_pop_data  = bus.inst_data;
        if (s_pop) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %0h, want no instruction (cycle %0d)", s_pop_pc, cyc);
            end else begin
                e = sb.pop_front();
                chk("inst_pc", s_pop_pc, e.pc);
                chk("inst_data", s_pop_data, e.data);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (drv_redir) begin
            sb.delete();
            exp_addr = drv_redir_pc;
            m_halted = 1'b0;
        end else begin
            if (s_fire) begin
                pend.push_back('{addr: s_fire_addr, due: cyc + lat});
                sb.push_back('{pc: exp_addr, data: memf(exp_addr)});
                exp_addr = exp_addr + 16'd1;
            end
`ifdef FETCH_HALT_DETECT_EN
            if (s_pop && s_pop_data == 16'hFFFF) m_halted = 1'b1;
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        drive_sample();
        advance();
    endtask

    task automatic clear_model();
        pend.delete();
        sb.delete();
        exp_addr       = RST_PC;
        m_halted       = 1'b0;
        drv_req_ready  = 1'b1;
        drv_inst_ready = 1'b1;
        drv_redir      = 1'b0;
        drv_redir_pc   = 16'h0000;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 16'h0000;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_pop(input int max, output logic ok,
                                 output logic [15:0] pc, output logic [15:0] data);
        ok = 1'b0;
        pc = 16'h0000;
        data = 16'h0000;
        for (int i = 0; i < max && !ok; i++) begin
            cycle();
            if (s_pop) begin
                ok = 1'b1;
                pc = s_pop_pc;
                data = s_pop_data;
            end
        end
    endtask

    initial begin
        logic        ok;
        logic [15:0] pc, data;
        int          n_fire, n_pop;
        logic [15:0] pcs[$];

        tbl[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h1000};
        tbl[3] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0001, 16'h1001};
        tbl[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h1002};
        tbl[5] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'h0003, 16'h1003};
        tbl[6] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'h1004};
        tbl[7] = '{1'b0, 1'b1, 16'h0007, 1'b1, 16'h0004, 16'h1004};
        tbl[8] = '{1'b1, 1'b0, 16'h0008, 1'b1, 16'h0004, 16'h1004};
        tbl[9] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0005, 16'h1005};

        clear_model();
        #2;
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_inst_data", bus.inst_data, 0);
        chk("rst_halted", bus.halted, 0);

        // Startup and back-to-back streaming, single-cycle imem.
        lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drv_inst_ready = tbl[i].inst_ready;
            drive_sample();
            chk($sformatf("tbl%0d_req_valid", i), bus.imem_req_valid, tbl[i].req_valid);
            chk($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].req_addr);
            chk($sformatf("tbl%0d_inst_valid", i), bus.inst_valid, tbl[i].inst_valid);
            chk($sformatf("tbl%0d_inst_pc", i), bus.inst_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_inst_data", i), bus.inst_data, tbl[i].data);
            advance();
        end

        // Decode stalled: credit limit caps issue at DEPTH words.
        do_reset();
        drv_inst_ready = 1'b0;
        n_fire = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_fire) n_fire++;
        end
        chk("stall_requests", n_fire, 4);
        drive_sample();
        chk("stall_req_valid_low", bus.imem_req_valid, 0);
        advance();
        drv_inst_ready = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_pop) n_pop++;
        end
        chk("stall_release_pops", n_pop >= 4, 1);

        // Redirect with two requests outstanding on a two-cycle imem.
        lat = 2;
        do_reset();
        cycle();
        cycle();
        drv_redir = 1'b1;
        drv_redir_pc = 16'h0040;
        cycle();
        drv_redir = 1'b0;
        drive_sample();
        chk("req_after_redirect", bus.imem_req_valid, 1);
        advance();
        run_until_pop(15, ok, pc, data);
        chk("redirect_pop_seen", ok, 1);
        chk("redirect_first_pc", pc, 16'h0040);
        chk("redirect_first_data", data, 16'h1040);

        // PC wrap across FFFF.
        lat = 1;
        do_reset();
        drv_redir = 1'b1;
        drv_redir_pc = 16'hFFFE;
        cycle();
        drv_redir = 1'b0;
        pcs.delete();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_pop) pcs.push_back(s_pop_pc);
        end
        chk("wrap_pop_count", pcs.size() >= 3, 1);
        if (pcs.size() >= 3) begin
            chk("wrap_pc0", pcs[0], 16'hFFFE);
            chk("wrap_pc1", pcs[1], 16'hFFFF);
            chk("wrap_pc2", pcs[2], 16'h0000);
        end

`ifdef FETCH_HALT_DETECT_EN
        // Halt word at PC 5 stops fetch and raises halted after it is consumed.
        do_reset();
        halt_en = 1'b1;
        for (int i = 0; i < 30 && !m_halted; i++) cycle();
        chk("halt_reached", m_halted, 1);
        for (int i = 0; i < 4; i++) begin
            drive_sample();
            chk("halt_no_request", bus.imem_req_valid, 0);
            chk("halt_no_inst", bus.inst_valid, 0);
            advance();
        end
        drv_redir = 1'b1;
        drv_redir_pc = 16'h0000;
        cycle();
        drv_redir = 1'b0;
        run_until_pop(10, ok, pc, data);
        chk("halt_resume_pop", ok, 1);
        chk("halt_resume_pc", pc, 16'h0000);
        halt_en = 1'b0;
`else
        // FFFF is an ordinary word: it is delivered and fetch continues.
        do_reset();
        drv_redir = 1'b1;
        drv_redir_pc = 16'hEFFE;
        cycle();
        drv_redir = 1'b0;
        n_pop = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_pop && s_pop_pc == 16'hF002) n_pop++;
        end
        chk("ffff_ordinary_continues", n_pop, 1);
`endif

        // Asynchronous reset mid-stream with the queue partly filled.
        lat = 1;
        do_reset();
        drv_inst_ready = 1'b0;
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_inst_valid", bus.inst_valid, 0);
        chk("midrst_halted", bus.halted, 0);
        chk("midrst_req_addr", bus.imem_req_addr, RST_PC);
        chk("midrst_req_valid", bus.imem_req_valid, 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_until_pop(10, ok, pc, data);
        chk("midrst_refetch_pop", ok, 1);
        chk("midrst_refetch_pc", pc, RST_PC);
        chk("midrst_refetch_data", data, 16'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
